// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with per-byte write enables and a self-timed zeroing sweep.
// Optional macro RAM_BYPASS_EN: a same-cycle read and write to one address returns the merged new word.
module ram_sdp_clr #(
  parameter int D_WIDTH      = 16,
  parameter int A_WIDTH      = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   address_write,
  input  logic [D_WIDTH-1:0]   data_write,
  input  logic                 write_enable,
  input  logic [D_WIDTH/8-1:0] byte_enable,
  input  logic [A_WIDTH-1:0]   address_read,
  input  logic                 read_enable,
  input  logic                 clear,
  output logic [D_WIDTH-1:0]   data_read,
  output logic                 read_valid,
  output logic                 busy
);

  localparam int NB    = D_WIDTH / 8;
  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = {A_WIDTH{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             r_state;
  logic [A_WIDTH-1:0] r_ptr;
  logic               r_busy;
  logic [D_WIDTH-1:0] r_mem [DEPTH];
  logic [D_WIDTH-1:0] r_q1;
  logic               r_v1;

  logic               w_we;
  logic [A_WIDTH-1:0] w_waddr;
  logic [D_WIDTH-1:0] w_wdata;
  logic [NB-1:0]      w_be;
  logic               w_rd_acc;
  logic [D_WIDTH-1:0] w_old;
  logic [D_WIDTH-1:0] w_rd_word;

  // Sweep controller: reset parks it in CLEAR so the array is zeroed after every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        CLEAR: begin
          r_ptr <= r_ptr + A_WIDTH'(1);
          if (r_ptr == LAST_ADDR) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Write-port mux: the sweep owns the port while busy; a clear request drops a same-cycle write.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = address_write;
    w_wdata = data_write;
    w_be    = byte_enable;
    if (rst) begin
      w_we = 1'b0;
    end else if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = '0;
      w_be    = '1;
    end else begin
      w_we = write_enable & ~clear;
    end
  end

  assign w_rd_acc = ~rst & (r_state == IDLE) & read_enable;
  assign w_old    = r_mem[address_read];

  // Read word selection, optionally forwarding bytes written in the same cycle.
  always_comb begin
    w_rd_word = w_old;
`ifdef RAM_BYPASS_EN
    if (w_we && (w_waddr == address_read)) begin
      for (int i = 0; i < NB; i++) begin
        w_rd_word[8*i +: 8] = w_be[i] ? w_wdata[8*i +: 8] : w_old[8*i +: 8];
      end
    end else begin
      w_rd_word = w_old;
    end
`endif
  end

  // Storage array; deliberately not reset, the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) begin
          r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_q1 <= '0;
    end else begin
      r_v1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_q1 <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [D_WIDTH-1:0] r_q2;
      logic               r_v2;
      // Extra output stage for the two-cycle read configuration.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_q2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_q2 <= r_q1;
          end
        end
      end
      assign data_read  = r_q2;
      assign read_valid = r_v2;
    end else begin : g_lat1
      assign data_read  = r_q1;
      assign read_valid = r_v1;
    end
  endgenerate

  assign busy = r_busy;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed scoreboard bench for ram_sdp_clr; runs a latency-1 and a latency-2 instance side by side.
module tb_ram_sdp_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  address_write = 5'd0;
  logic [15:0] data_write = 16'h0000;
  logic        write_enable = 1'b0;
  logic [1:0]  byte_enable = 2'b00;
  logic [4:0]  address_read = 5'd0;
  logic        read_enable = 1'b0;
  logic        clear = 1'b0;

  logic [15:0] d1, d2;
  logic        v1, v2, b1, b2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mdl [32];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic        tb_acc = 1'b0;
  logic        e1, e2;

  always #5 clk = ~clk;

  ram_sdp_clr #(.D_WIDTH(16), .A_WIDTH(5), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .address_write(address_write), .data_write(data_write),
    .write_enable(write_enable), .byte_enable(byte_enable), .address_read(address_read),
    .read_enable(read_enable), .clear(clear), .data_read(d1), .read_valid(v1), .busy(b1)
  );

  ram_sdp_clr #(.D_WIDTH(16), .A_WIDTH(5), .READ_LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .address_write(address_write), .data_write(data_write),
    .write_enable(write_enable), .byte_enable(byte_enable), .address_read(address_read),
    .read_enable(read_enable), .clear(clear), .data_read(d2), .read_valid(v2), .busy(b2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected read-valid timing, built from the reads the bench expects to be accepted.
  always @(posedge clk) begin
    if (rst) begin
      e1 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      e1 <= tb_acc;
      e2 <= e1;
    end
  end

  // Scoreboard: compare valid every cycle and pop expected data on each expected result.
  always @(negedge clk) begin
    logic [15:0] x;
    check("valid_l1", v1, e1);
    check("valid_l2", v2, e2);
    if (e1) begin
      check("q1_avail", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        x = q1.pop_front();
        check("rdata_l1", d1, x);
      end
    end
    if (e2) begin
      check("q2_avail", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        x = q2.pop_front();
        check("rdata_l2", d2, x);
      end
    end
  end

  // One stimulus cycle; acc says whether the bench expects the block to be idle and accepting.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [4:0] ra,
                       input logic clr, input logic acc);
    logic [15:0] rexp;
    write_enable  = we;
    address_write = wa;
    data_write    = wd;
    byte_enable   = be;
    read_enable   = re;
    address_read  = ra;
    clear         = clr;
    tb_acc        = re & acc;
    rexp = mdl[ra];
`ifdef RAM_BYPASS_EN
    if (we && acc && !clr && (wa == ra)) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) rexp[8*i +: 8] = wd[8*i +: 8];
      end
    end
`endif
    if (re && acc) begin
      q1.push_back(rexp);
      q2.push_back(rexp);
    end
    @(negedge clk);
    if (acc && clr) begin
      for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    end else if (acc && we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) mdl[wa][8*i +: 8] = wd[8*i +: 8];
      end
    end
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear        = 1'b0;
    tb_acc       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b0, 5'd0, 1'b0, 1'b1);
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (b1 === 1'b1 && n < 100) begin
      idle(1);
      n++;
    end
    check(tag, n, 32);
    check({tag, "_l2_done"}, b2, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy_l1", b1, 1'b1);
    check("rst_busy_l2", b2, 1'b1);
    check("rst_data_l1", d1, 16'h0000);
    check("rst_data_l2", d2, 16'h0000);
    rst = 1'b0;
    count_busy("reset_sweep_len");
    check("post_sweep_data", d1, 16'h0000);

    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd7, 1'b0, 1'b1);

    drive(1'b1, 5'd3, 16'hABCD, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 16'h1234, 2'b01, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 16'h5600, 2'b10, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 1'b1);
    idle(3);
    check("hold_l1", d1, 16'h5634);
    check("hold_l2", d2, 16'h5634);

    drive(1'b1, 5'd1, 16'h1001, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd2, 16'h2002, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd3, 16'h3003, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd1, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd2, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 1'b1);

    drive(1'b1, 5'd9, 16'hBEEF, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd9, 1'b0, 1'b1);

    drive(1'b1, 5'd5, 16'h1111, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd5, 16'h2222, 2'b11, 1'b1, 5'd5, 1'b0, 1'b1);
    drive(1'b1, 5'd5, 16'h0033, 2'b01, 1'b1, 5'd5, 1'b0, 1'b1);
    drive(1'b1, 5'd10, 16'hC0DE, 2'b11, 1'b1, 5'd9, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd5, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd10, 1'b0, 1'b1);
    idle(3);

    for (int a = 0; a < 32; a++) drive(1'b1, a[4:0], 16'hFFFF, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b1, 5'd0, 16'h5555, 2'b11, 1'b1, 5'd4, 1'b1, 1'b1);
    n = 0;
    while (b1 === 1'b1 && n < 100) begin
      drive(1'b1, n[4:0], 16'h7777, 2'b11, 1'b1, n[4:0], (n == 5), 1'b0);
      n++;
    end
    check("clear_busy_len", n, 32);
    check("clear_hold_l1", d1, 16'hFFFF);
    check("clear_hold_l2", d2, 16'hFFFF);
    for (int a = 0; a < 32; a++) drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, a[4:0], 1'b0, 1'b1);
    idle(3);

    drive(1'b1, 5'd3, 16'h4444, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midread_rst_data_l1", d1, 16'h0000);
    check("midread_rst_data_l2", d2, 16'h0000);
    check("midread_rst_busy", b1, 1'b1);
    @(negedge clk);
    q1.delete();
    q2.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    rst = 1'b0;
    count_busy("midread_rst_sweep_len");

    drive(1'b1, 5'd6, 16'h6666, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
    idle(10);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_busy("midsweep_rst_len");
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd6, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd31, 1'b0, 1'b1);
    idle(4);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
